// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// Single-bit full-adder cell; purely combinational.
module adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell, one operand bit per clock, LSB first.
// Result valid WIDTH edges after accept; holds in DONE until res_ready_i, no request accepted outside IDLE.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_sub_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_carry_o,
  output logic             res_ovf_o,
  output logic             res_zero_o,
  output logic             busy_o
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             bit_sum, bit_carry;
  logic             last_bit;

  logic [WIDTH-1:0] res_sum_q;
  logic             res_carry_q, res_ovf_q, res_zero_q;

  assign last_bit = (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = RUN;
      RUN:     if (last_bit)    state_d = DONE;
      DONE:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready_o = (state_q == IDLE);
    res_valid_o = (state_q == DONE);
    busy_o      = (state_q == RUN);
  end

  adder u_adder (
    .a_i     (a_q[cnt_q]),
    .b_i     (b_q[cnt_q]),
    .carry_i (carry_q),
    .sum_o   (bit_sum),
    .carry_o (bit_carry)
  );

  always_comb begin
    acc_nxt        = acc_q;
    acc_nxt[cnt_q] = bit_sum;
  end

  // Subtraction is a + ~b + 1: invert B at accept and seed the carry with 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_zero_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (req_valid_i) begin
        a_q     <= req_a_i;
        b_q     <= req_sub_i ? ~req_b_i : req_b_i;
        carry_q <= req_sub_i;
        cnt_q   <= '0;
        acc_q   <= '0;
      end
    end else if (state_q == RUN) begin
      acc_q   <= acc_nxt;
      carry_q <= bit_carry;
      if (last_bit) begin
        // carry_q here is the carry into the MSB
        res_sum_q   <= acc_nxt;
        res_carry_q <= bit_carry;
        res_ovf_q   <= carry_q ^ bit_carry;
        res_zero_q  <= (acc_nxt == '0);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign res_sum_o   = res_sum_q;
  assign res_carry_o = res_carry_q;
  assign res_ovf_o   = res_ovf_q;
  assign res_zero_o  = res_zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=32.
module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_sub;
  logic [W-1:0] req_a, req_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry, res_ovf, res_zero, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_sub_i   (req_sub),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum_o   (res_sum),
    .res_carry_o (res_carry),
    .res_ovf_o   (res_ovf),
    .res_zero_o  (res_zero),
    .busy_o      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] s, input logic c,
                         input logic o, input logic z);
    chk32({tag, ":sum"}, res_sum, s);
    chk1({tag, ":carry"}, res_carry, c);
    chk1({tag, ":ovf"}, res_ovf, o);
    chk1({tag, ":zero"}, res_zero, z);
  endtask

  // Independent reference: full-width arithmetic, overflow from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bb;
    logic [32:0] t;
    logic        o;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    o  = (a[31] == bb[31]) && (t[31] != a[31]);
    return {t[32], o, (t[31:0] == 32'd0), t[31:0]};
  endfunction

  // Accept, scramble operand inputs during RUN, check exact latency, check result, handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez);
    chk1({tag, ":ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b; req_sub = sub;
    tick;
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_sub = ~sub;
    chk1({tag, ":busy"}, busy, 1'b1);
    for (int i = 1; i < W; i++) tick;
    chk1({tag, ":valid_early"}, res_valid, 1'b0);
    tick;
    chk1({tag, ":valid"}, res_valid, 1'b1);
    chk_res(tag, es, ec, eo, ez);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk1({tag, ":idle"}, req_ready, 1'b1);
  endtask

  logic [31:0] va [5];
  logic [31:0] vb [5];
  logic        vs [5];
  logic [34:0] m;
  int          k, cyc, last;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk1("rst:ready", req_ready, 1'b1);
    chk1("rst:valid", res_valid, 1'b0);
    chk1("rst:busy", busy, 1'b0);
    chk_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);

    run_op("add5_3",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    run_op("addwrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("addovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub3_5",   32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub5_5",   32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("subovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Last result retained in IDLE
    tick;
    chk_res("retain", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Stall in DONE while requests and operands churn
    req_valid = 1'b1; req_a = 32'h1234_5678; req_b = 32'h1111_1111; req_sub = 1'b0;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < W; i++) tick;
    chk1("stall:enter", res_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      req_valid = ~req_valid; req_a = $urandom; req_b = $urandom; req_sub = ~req_sub;
      tick;
    end
    chk1("stall:valid", res_valid, 1'b1);
    chk1("stall:ready", req_ready, 1'b0);
    chk1("stall:busy", busy, 1'b0);
    chk_res("stall", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b0; res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk1("stall:exit", req_ready, 1'b1);

    // Reset while the counter sits at bit 15
    req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h0101_0101; req_sub = 1'b0;
    tick;
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    chk1("midrst:busy_before", busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk1("midrst:ready", req_ready, 1'b1);
    chk1("midrst:busy", busy, 1'b0);
    chk1("midrst:valid", res_valid, 1'b0);
    chk_res("midrst", 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("post_rst", 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);

    // Back-to-back with request and result handshakes held high
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; vs[0] = 1'b0;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vs[1] = 1'b0;
    va[2] = 32'h0000_0000; vb[2] = 32'h0000_0001; vs[2] = 1'b1;
    va[3] = 32'hA5A5_A5A5; vb[3] = 32'h5A5A_5A5A; vs[3] = 1'b0;
    va[4] = 32'h7FFF_FFFF; vb[4] = 32'hFFFF_FFFF; vs[4] = 1'b1;
    k = 0; cyc = 0; last = -1;
    req_a = va[0]; req_b = vb[0]; req_sub = vs[0];
    req_valid = 1'b1; res_ready = 1'b1;
    while (k < 5 && cyc < 400) begin
      tick;
      cyc++;
      if (res_valid) begin
        m = model(va[k], vb[k], vs[k]);
        chk_res("b2b", m[31:0], m[34], m[33], m[32]);
        if (last >= 0) chk32("b2b:period", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        k++;
        if (k < 5) begin
          req_a = va[k]; req_b = vb[k]; req_sub = vs[k];
        end
      end
    end
    chk32("b2b:count", 32'(k), 32'd5);
    req_valid = 1'b0; res_ready = 1'b0;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 req_valid_i  input  1  operation request valid.
REQ-005 req_ready_o  output  1  controller can accept a request.
REQ-006 req_sub_i  input  1  0 = a+b, 1 = a-b.
REQ-007 req_a_i  input  WIDTH  operand A.
REQ-008 req_b_i  input  WIDTH  operand B.
REQ-009 res_valid_o  output  1  result valid.
REQ-010 res_ready_i  input  1  consumer accepts result.
REQ-011 res_sum_o  output  WIDTH  sum/difference.
REQ-012 res_carry_o  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-013 res_ovf_o  output  1  signed overflow.
REQ-014 res_zero_o  output  1  res_sum_o == 0.
REQ-015 busy_o  output  1  high while state is RUN.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; only IDLE accepts requests, only DONE presents results.
REQ-017 req_ready_o SHALL equal (state == IDLE); res_valid_o SHALL equal (state == DONE).
REQ-018 Request accepted on an edge with req_valid_i & req_ready_o: latch A, B (B bitwise-inverted when req_sub_i), carry register = req_sub_i, bit counter = 0, go to RUN.
REQ-019 Each RUN edge SHALL feed bit[counter] of A and B plus the carry register into one 1-bit full-adder cell, write its sum to result bit[counter], its carry to the carry register, and increment counter.
REQ-020 Edge processing bit WIDTH-1 SHALL also capture carry-in of MSB for overflow and move to DONE; latency from accept edge to res_valid_o high = exactly WIDTH edges.
REQ-021 res_ovf_o SHALL equal carry into MSB XOR carry out of MSB; res_zero_o derived from final result.
REQ-022 Result outputs SHALL be stable throughout DONE; DONE exits to IDLE on the edge with res_ready_i high.
REQ-023 No same-cycle result-to-request bypass: a new request can be accepted earliest one cycle after result handshake.
REQ-024 req_valid_i during RUN or DONE SHALL be ignored and not latched; operand inputs changing during RUN SHALL not affect the result.
REQ-025 res_ready_i outside DONE SHALL have no effect.
REQ-026 Counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap inside RUN (terminal count leaves RUN).
REQ-027 res_sum_o, res_carry_o, res_ovf_o, res_zero_o SHALL retain the last completed result in IDLE until overwritten by the next completion.

Reset
REQ-028 rst_i high at an edge SHALL force IDLE, counter 0, carry register 0, all result outputs 0, regardless of state (including mid-RUN, discarding the operation).
REQ-029 After reset: req_ready_o=1, res_valid_o=0, busy_o=0, res_sum_o=0, res_carry_o=0, res_ovf_o=0, res_zero_o=0 (zero flag reset to 0, not computed).
REQ-030 rst_i SHALL take priority over any simultaneous request or result handshake.

Structure
REQ-031 Package serial_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-032 The block SHALL instantiate exactly one existing 1-bit full-adder cell `adder` (a_i, b_i, carry_i -> sum_o, carry_o); no other arithmetic on operands.

Verification
REQ-033 WIDTH=32, A=0x0000_0005, B=0x0000_0003, add -> after 32 edges sum=0x0000_0008, carry=0, ovf=0, zero=0.
REQ-034 A=0xFFFF_FFFF, B=0x0000_0001, add -> sum=0, carry=1, ovf=0, zero=1.
REQ-035 A=0x7FFF_FFFF, B=0x0000_0001, add -> sum=0x8000_0000, ovf=1, carry=0; A=0x0000_0003, B=0x0000_0005, sub -> sum=0xFFFF_FFFE, carry=0 (borrow), ovf=0.
REQ-036 Hold res_ready_i=0 for 10 cycles in DONE while toggling req_valid_i and operands -> outputs unchanged, req_ready_o=0, no new operation started.
REQ-037 Assert rst_i at RUN bit 15 -> next edge IDLE, all outputs 0; new request 1+1 completes normally with sum=2.
REQ-038 Back-to-back: res_ready_i and req_valid_i held high -> accepts every WIDTH+2 cycles, each result correct against a reference model.
